// File: rtl/red_seq.sv
// red_seq: signed nibble-pair reduction sequencer.
// Accepts two 16-bit operands, each holding four signed 4-bit nibbles. It then
// sums all eight nibbles over four cycles using a single 5-bit pair adder and
// a 7-bit accumulator. The result is presented sign-extended on s with a
// valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair offered
//   in_ready   sequencer can accept operands (IDLE and not in reset)
//   a, b       operands, four signed 4-bit nibbles each
//   abort      synchronous cancel of any operation in flight
//   out_valid  result on s is valid (DONE)
//   out_ready  consumer accepts result
//   s          last completed result, sign-extended to 16 bits
//   busy       state is not IDLE
//
// state | meaning
// IDLE  | waiting for an operand pair
// ACC   | accumulating nibble pair cnt (LSB nibble first)
// DONE  | result presented, waiting for out_ready
module red_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] s,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] a_q, b_q;
    logic [1:0]  cnt;
    logic [6:0]  acc;
    logic [3:0]  nib_a, nib_b;
    logic [4:0]  pair;
    logic [6:0]  acc_sum;

    // Shared datapath: select the current nibble pair, add, and accumulate.
    always_comb begin
        nib_a = a_q[3:0];
        nib_b = b_q[3:0];
        case (cnt)
            2'd0: begin nib_a = a_q[3:0];   nib_b = b_q[3:0];   end
            2'd1: begin nib_a = a_q[7:4];   nib_b = b_q[7:4];   end
            2'd2: begin nib_a = a_q[11:8];  nib_b = b_q[11:8];  end
            default: begin nib_a = a_q[15:12]; nib_b = b_q[15:12]; end
        endcase
        pair    = {nib_a[3], nib_a} + {nib_b[3], nib_b};
        acc_sum = acc + {{2{pair[4]}}, pair};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ACC;
            ACC:     if (cnt == 2'd3) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // in_ready also depends on rst so that it reads low during reset.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            acc   <= 7'd0;
            s     <= 16'h0000;
            a_q   <= 16'h0000;
            b_q   <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (abort) begin
                cnt <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            a_q <= a;
                            b_q <= b;
                            acc <= 7'd0;
                            cnt <= 2'd0;
                        end
                    end
                    ACC: begin
                        acc <= acc_sum;
                        cnt <= cnt + 2'd1;
                        // s is only written on the edge that enters DONE.
                        if (cnt == 2'd3) s <= {{9{acc_sum[6]}}, acc_sum};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_red_seq.sv
module tb_red_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, abort, out_valid, out_ready, busy;
    logic [15:0] a, b, s;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit started = 1'b0;

    typedef struct {
        logic [15:0] val;
        int          acc_cyc;
    } exp_t;
    exp_t exp_q[$];

    red_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation when out_valid rises, checks value and
    // latency, then checks s stays stable while out_valid is held.
    logic        prev_ov = 1'b0;
    logic [15:0] cur_exp = 16'h0;
    always @(negedge clk) begin
        if (started) begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    cur_exp = e.val;
                    check("result_s", {16'h0, s}, {16'h0, e.val});
                    check("latency", cyc - e.acc_cyc, 32'd4);
                end
            end else if (out_valid && prev_ov) begin
                check("s_stable", {16'h0, s}, {16'h0, cur_exp});
            end
            prev_ov = out_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                         input bit push, input logic [15:0] expv);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        a = av; b = bv; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
        if (push) begin
            exp_t e;
            e.val = expv;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume();
        wait_valid();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0;
        repeat (3) step();
        check("rst_s", {16'h0, s}, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        started = 1'b1;

        issue(16'h8888, 16'h8888, 1, 16'hFFC0); consume();
        issue(16'h9999, 16'h7777, 1, 16'h0000); consume();
        issue(16'h7777, 16'h7777, 1, 16'h0038); consume();

        // operands change after capture
        issue(16'h8888, 16'h8888, 1, 16'hFFC0);
        a = 16'hFFFF; b = 16'hFFFF;
        consume();
        a = 16'h0; b = 16'h0;

        // backpressure in DONE
        issue(16'h7777, 16'h7777, 1, 16'h0038);
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_s", {16'h0, s}, 32'h0038);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_busy", {31'd0, busy}, 32'd0);

        // abort on the second ACC cycle
        issue(16'h9999, 16'h7777, 0, 16'h0);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_s_kept", {16'h0, s}, 32'h0038);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (6) step();
        issue(16'h1234, 16'h1111, 1, 16'h000E); consume();

        // abort wins over in_valid in IDLE
        a = 16'h8888; b = 16'h8888; in_valid = 1'b1; abort = 1'b1;
        step();
        in_valid = 1'b0; abort = 1'b0;
        check("abort_vs_valid_busy", {31'd0, busy}, 32'd0);
        check("abort_vs_valid_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) step();
        check("abort_vs_valid_s", {16'h0, s}, 32'h000E);

        // abort with out_ready in DONE
        issue(16'h7777, 16'h7777, 1, 16'h0038);
        wait_valid();
        abort = 1'b1; out_ready = 1'b1;
        step();
        abort = 1'b0; out_ready = 1'b0;
        check("abort_done_busy", {31'd0, busy}, 32'd0);
        check("abort_done_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_done_in_ready", {31'd0, in_ready}, 32'd1);

        // reset mid-ACC
        issue(16'h8888, 16'h8888, 0, 16'h0);
        step();
        rst = 1'b1;
        step();
        check("midrst_s", {16'h0, s}, 32'h0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (6) step();

        issue(16'h1234, 16'h1111, 1, 16'h000E); consume();
        repeat (2) step();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
